// File: rtl/booth_pkg.sv
// Shared types and default widths for the Booth product accumulator datapath.
package booth_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_e;

  localparam int PROD_W = 8;
  localparam int ACC_W  = 10;
  localparam int CNT_W  = 4;

  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

endpackage

// File: rtl/sat_adder.sv
// Combinational signed saturating add of a sign-extended product into an accumulator.
module sat_adder #(
  parameter int ACC_W  = booth_pkg::ACC_W,
  parameter int PROD_W = booth_pkg::PROD_W
) (
  input  logic [ACC_W-1:0]  acc,
  input  logic [PROD_W-1:0] prod,
  output logic [ACC_W-1:0]  sum,
  output logic              ovf
);

  logic [ACC_W:0] acc_ext;
  logic [ACC_W:0] prod_ext;
  logic [ACC_W:0] wide;

  always_comb begin
    acc_ext  = {acc[ACC_W-1], acc};
    prod_ext = {{(ACC_W+1-PROD_W){prod[PROD_W-1]}}, prod};
    wide     = acc_ext + prod_ext;
    // One guard bit: a disagreement between the top two bits means the result left range.
    ovf      = wide[ACC_W] ^ wide[ACC_W-1];
    if (ovf) begin
      sum = wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end else begin
      sum = wide[ACC_W-1:0];
    end
  end

endmodule

// File: rtl/booth_product_accumulator.sv
// Accumulates a programmed number of signed Booth products into a saturating sum,
// presented on a valid/ready handshake.
module booth_product_accumulator #(
  parameter int PROD_W = booth_pkg::PROD_W,
  parameter int ACC_W  = booth_pkg::ACC_W,
  parameter int CNT_W  = booth_pkg::CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [CNT_W-1:0]  len,
  input  logic              prod_valid,
  input  logic [PROD_W-1:0] prod,
  output logic              prod_ready,
  output logic              sum_valid,
  output logic [ACC_W-1:0]  sum,
  input  logic              sum_ready,
  output logic              overflow,
  output logic              busy
);

  import booth_pkg::*;

  state_e            state_q, state_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]  remaining_q, remaining_d;
  logic              overflow_q, overflow_d;

  logic [ACC_W-1:0]  add_sum;
  logic              add_ovf;

  sat_adder #(
    .ACC_W  (ACC_W),
    .PROD_W (PROD_W)
  ) u_sat_adder (
    .acc  (acc_q),
    .prod (prod),
    .sum  (add_sum),
    .ovf  (add_ovf)
  );

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    remaining_d = remaining_q;
    overflow_d  = overflow_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          acc_d       = '0;
          overflow_d  = 1'b0;
          remaining_d = len;
          state_d     = (len == '0) ? HOLD : ACCUM;
        end
      end
      ACCUM: begin
        if (prod_valid) begin
          acc_d       = add_sum;
          overflow_d  = overflow_q | add_ovf;
          remaining_d = remaining_q - CNT_W'(1);
          if (remaining_q == CNT_W'(1)) begin
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (sum_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      remaining_q <= '0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      remaining_q <= remaining_d;
      overflow_q  <= overflow_d;
    end
  end

  always_comb begin
    prod_ready = (state_q == ACCUM);
    sum_valid  = (state_q == HOLD);
    busy       = (state_q != IDLE);
    sum        = acc_q;
    overflow   = overflow_q;
  end

endmodule

// File: tb/tb_booth_product_accumulator.sv
// Directed bench for booth_product_accumulator: vector table of jobs plus hand-written corner sequences.
module tb_booth_product_accumulator;

  localparam int PROD_W = 8;
  localparam int ACC_W  = 10;
  localparam int CNT_W  = 4;
  localparam int NVEC   = 8;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic [CNT_W-1:0]  len;
  logic              prod_valid;
  logic [PROD_W-1:0] prod;
  logic              prod_ready;
  logic              sum_valid;
  logic [ACC_W-1:0]  sum;
  logic              sum_ready;
  logic              overflow;
  logic              busy;

  booth_product_accumulator #(
    .PROD_W (PROD_W),
    .ACC_W  (ACC_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .len        (len),
    .prod_valid (prod_valid),
    .prod       (prod),
    .prod_ready (prod_ready),
    .sum_valid  (sum_valid),
    .sum        (sum),
    .sum_ready  (sum_ready),
    .overflow   (overflow),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int len;
    int p[16];
    int exp_sum;
    int exp_ovf;
  } vec_t;

  vec_t vecs[NVEC];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic check(input string name, input int got, input int exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
  endtask

  function automatic int ssum();
    return int'($signed(sum));
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input int i);
    start = 1'b1;
    len   = CNT_W'(vecs[i].len);
    tick();
    start = 1'b0;
    for (int k = 0; k < vecs[i].len; k++) begin
      check($sformatf("v%0d ready k%0d", i, k), int'(prod_ready), 1);
      check($sformatf("v%0d no early valid k%0d", i, k), int'(sum_valid), 0);
      prod_valid = 1'b1;
      prod       = PROD_W'(vecs[i].p[k]);
      tick();
    end
    prod_valid = 1'b0;
    prod       = '0;
    check($sformatf("v%0d sum_valid", i), int'(sum_valid), 1);
    check($sformatf("v%0d sum", i), ssum(), vecs[i].exp_sum);
    check($sformatf("v%0d overflow", i), int'(overflow), vecs[i].exp_ovf);
    check($sformatf("v%0d ready in hold", i), int'(prod_ready), 0);
    sum_ready = 1'b1;
    tick();
    sum_ready = 1'b0;
    check($sformatf("v%0d idle busy", i), int'(busy), 0);
    check($sformatf("v%0d idle sum_valid", i), int'(sum_valid), 0);
    check($sformatf("v%0d idle sum kept", i), ssum(), vecs[i].exp_sum);
  endtask

  initial begin
    // job table: len, products, expected sum, expected overflow
    for (int i = 0; i < NVEC; i++) begin
      vecs[i].len = 0;
      for (int k = 0; k < 16; k++) vecs[i].p[k] = 0;
    end
    vecs[0].len = 2;  vecs[0].p[0] = 35; vecs[0].p[1] = 21;
    vecs[0].exp_sum = 56;   vecs[0].exp_ovf = 0;
    vecs[1].len = 10; for (int k = 0; k < 10; k++) vecs[1].p[k] = 64;
    vecs[1].exp_sum = 511;  vecs[1].exp_ovf = 1;
    vecs[2].len = 10; for (int k = 0; k < 10; k++) vecs[2].p[k] = -56;
    vecs[2].exp_sum = -512; vecs[2].exp_ovf = 1;
    vecs[3].len = 1;  vecs[3].p[0] = 3;
    vecs[3].exp_sum = 3;    vecs[3].exp_ovf = 0;
    vecs[4].len = 0;
    vecs[4].exp_sum = 0;    vecs[4].exp_ovf = 0;
    vecs[5].len = 15;
    for (int k = 0; k < 5; k++) vecs[5].p[k] = 127;
    for (int k = 5; k < 15; k++) vecs[5].p[k] = -1;
    vecs[5].exp_sum = 501;  vecs[5].exp_ovf = 1;
    vecs[6].len = 4;  for (int k = 0; k < 4; k++) vecs[6].p[k] = -128;
    vecs[6].exp_sum = -512; vecs[6].exp_ovf = 0;
    vecs[7].len = 5;  for (int k = 0; k < 4; k++) vecs[7].p[k] = 127;
    vecs[7].p[4] = 3;
    vecs[7].exp_sum = 511;  vecs[7].exp_ovf = 0;

    rst_n = 1'b0; start = 1'b0; len = '0; prod_valid = 1'b0; prod = '0; sum_ready = 1'b0;
    #12;
    check("rst prod_ready", int'(prod_ready), 0);
    check("rst sum_valid", int'(sum_valid), 0);
    check("rst sum", ssum(), 0);
    check("rst busy", int'(busy), 0);
    check("rst overflow", int'(overflow), 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < NVEC; i++) run_vec(i);

    // prod_valid in IDLE is ignored, then a gapped signed job
    prod_valid = 1'b1; prod = PROD_W'(100);
    tick();
    check("idle prod_ready", int'(prod_ready), 0);
    tick();
    prod_valid = 1'b0;
    start = 1'b1; len = CNT_W'(3);
    tick();
    start = 1'b0;
    check("mix busy", int'(busy), 1);
    check("mix cleared", ssum(), 0);
    prod_valid = 1'b1; prod = PROD_W'(-56);
    tick();
    prod_valid = 1'b0; prod = PROD_W'(99);
    for (int g = 0; g < 2; g++) begin
      check($sformatf("mix gap ready %0d", g), int'(prod_ready), 1);
      check($sformatf("mix gap sum %0d", g), ssum(), -56);
      tick();
    end
    prod_valid = 1'b1; prod = PROD_W'(64);
    tick();
    check("mix ready before last", int'(prod_ready), 1);
    prod = PROD_W'(-1);
    tick();
    prod_valid = 1'b0;
    check("mix sum_valid", int'(sum_valid), 1);
    check("mix sum", ssum(), 7);
    check("mix overflow", int'(overflow), 0);
    sum_ready = 1'b1;
    tick();
    sum_ready = 1'b0;

    // backpressure in HOLD with ignored start pulses
    start = 1'b1; len = CNT_W'(2);
    tick();
    start = 1'b0;
    prod_valid = 1'b1; prod = PROD_W'(10);
    tick();
    prod = PROD_W'(20);
    tick();
    prod_valid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      check($sformatf("bp valid %0d", c), int'(sum_valid), 1);
      check($sformatf("bp sum %0d", c), ssum(), 30);
      start = 1'b1; len = CNT_W'(3);
      tick();
      start = 1'b0;
    end
    check("bp still hold", int'(sum_valid), 1);
    check("bp sum after starts", ssum(), 30);
    sum_ready = 1'b1;
    tick();
    sum_ready = 1'b0;
    check("bp idle busy", int'(busy), 0);
    check("bp idle valid", int'(sum_valid), 0);
    check("bp idle sum kept", ssum(), 30);
    tick();
    check("bp no relatch", int'(busy), 0);

    // abort with async reset mid-ACCUM
    start = 1'b1; len = CNT_W'(5);
    tick();
    start = 1'b0;
    prod_valid = 1'b1; prod = PROD_W'(50);
    tick();
    tick();
    check("abort pre sum", ssum(), 100);
    check("abort pre ready", int'(prod_ready), 1);
    #2 rst_n = 1'b0;
    #1;
    check("abort ready", int'(prod_ready), 0);
    check("abort busy", int'(busy), 0);
    check("abort sum", ssum(), 0);
    check("abort valid", int'(sum_valid), 0);
    prod_valid = 1'b0;
    #2 rst_n = 1'b1;
    tick();
    tick();
    check("abort stays idle", int'(busy), 0);
    check("abort no partial", int'(sum_valid), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
